fetch_queue: RTL and testbench

//  Parametrised prefetching instruction-fetch stage. Replaces the single-cycle PC+imem fetch.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the prefetching fetch stage: default geometry,
// response classification and counter-width helper.
package fetch_queue_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_STEP = 2;
    localparam int DEF_DEPTH   = 4;

    // What the top does with the memory response presented this cycle.
    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_PUSH,
        RSP_DROP,
        RSP_ERR
    } rsp_action_e;

    // Counters must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: DEPTH entries of {pc, instr}, synchronous reset and flush,
// simultaneous push/pop, occupancy count.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_INSTR_W,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pop on empty is ignored; push on full is accepted only alongside a pop.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only observable once
    // count says it was written, so clearing it would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: credit-limited in-order requests to a variable-latency
// instruction memory, queued responses to decode, redirect flush and halt.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_inc,
    input  logic               instr_ready,
    output logic               err
);

    localparam int                CNT_W = cnt_width(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0]         fetch_pc;
    logic [ADDR_W-1:0]         rsp_pc;      // PC of the next non-stale response
    logic [CNT_W-1:0]          outstanding;
    logic [CNT_W-1:0]          drop_cnt;
    logic                      err_q;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W:0]            credit_used;
    logic [ADDR_W+INSTR_W-1:0] head_data;
    logic [ADDR_W-1:0]         head_pc;
    logic [ADDR_W-1:0]         redirect_target;
    logic                      misaligned;
    logic                      issue;
    logic                      rsp_taken;
    logic                      push;
    logic                      pop;
    logic                      head_valid;
    rsp_action_e               rsp_action;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        rsp_action = RSP_NONE;
        if (imem_rsp_valid) begin
            if (outstanding == '0)                  rsp_action = RSP_ERR;
            else if (redirect || drop_cnt != '0)    rsp_action = RSP_DROP;
            else                                    rsp_action = RSP_PUSH;
        end

        credit_used     = {1'b0, fifo_count} + {1'b0, outstanding};
        imem_req        = !rst && !halt && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
        issue           = imem_req && imem_ready;
        rsp_taken       = (rsp_action == RSP_PUSH) || (rsp_action == RSP_DROP);
        push            = (rsp_action == RSP_PUSH);
        head_valid      = !rst && (fifo_count != '0);
        pop             = head_valid && instr_ready && !redirect;
        misaligned      = (redirect_pc & ALIGN) != '0;
        redirect_target = redirect_pc & ~ALIGN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp_taken);
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding - CNT_W'(rsp_taken);
            end else begin
                if (issue) fetch_pc <= fetch_pc + STEP;
                if (push)  rsp_pc   <= rsp_pc + STEP;
                if (rsp_action == RSP_DROP) drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (rsp_action == RSP_ERR || (redirect && misaligned)) err_q <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign head_pc      = head_data[ADDR_W+INSTR_W-1:INSTR_W];
    assign imem_addr    = rst ? RESET_PC : fetch_pc;
    assign instr_valid  = head_valid;
    assign instr        = head_valid ? head_data[INSTR_W-1:0] : '0;
    assign instr_pc     = head_valid ? head_pc : '0;
    assign instr_pc_inc = head_valid ? head_pc + STEP : '0;
    assign err          = err_q && !rst;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model answers requests in order,
// expected {pc, instr} are queued at issue and checked when decode pops.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_inc;
    logic        instr_ready = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_inc   (instr_pc_inc),
        .instr_ready    (instr_ready),
        .err            (err)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] gen_pc = '0;
    logic [15:0] mon_pc;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          pop_cnt = 0;
    int          mem_lat = 1;

    logic        k_rst = 1'b1;
    logic        k_instr_ready = 1'b1;
    logic        k_imem_ready = 1'b1;
    logic        k_halt = 1'b0;
    logic        k_redirect = 1'b0;
    logic [15:0] k_redirect_pc = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive knobs and memory response after the edge, then account
    // for what the DUT will do at the coming edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst         = k_rst;
        instr_ready = k_instr_ready;
        imem_ready  = k_imem_ready;
        halt        = k_halt;
        redirect    = k_redirect;
        redirect_pc = k_redirect_pc;
        if (!k_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'($urandom);
        end
        @(negedge clk);
        #1;
        if (!rst) begin
            if (imem_rsp_valid) void'(mem_q.pop_front());
            if (halt || redirect) begin
                check("req_blocked", imem_req, 0);
            end else if (imem_req && imem_ready) begin
                check("imem_addr", imem_addr, gen_pc);
                mem_q.push_back(mem_req_t'{addr: imem_addr, due: cyc + mem_lat});
                exp_q.push_back(gen_pc);
                gen_pc = gen_pc + 16'd2;
                issue_cnt++;
                check("credit", exp_q.size() <= DEPTH, 1);
            end
            if (redirect) begin
                exp_q.delete();
                gen_pc = redirect_pc & 16'hFFFE;
            end
        end
    endtask

    task automatic do_reset(input int lat);
        k_rst      = 1'b1;
        k_redirect = 1'b0;
        k_halt     = 1'b0;
        step();
        step();
        mem_q.delete();
        exp_q.delete();
        gen_pc  = '0;
        mem_lat = lat;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_err", err, 0);
        k_rst = 1'b0;
    endtask

    // Monitor: every decode handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", exp_q.size(), 1);
            end else begin
                mon_pc = exp_q.pop_front();
                check("instr_pc", instr_pc, mon_pc);
                check("instr", instr, mem_word(mon_pc));
                check("instr_pc_inc", instr_pc_inc, 16'(mon_pc + 16'd2));
                pop_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int p0;
        bit found;

        // Streaming start-up with a 1-cycle memory.
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_addr", imem_addr, 16'(2 * k));
            check("t1_valid", instr_valid, k >= 2);
        end

        // Decode stalled: credits cap issues at DEPTH, then drain in order.
        do_reset(1);
        k_instr_ready = 1'b0;
        i0 = issue_cnt;
        repeat (10) step();
        check("t2_issues", issue_cnt - i0, 4);
        check("t2_req_off", imem_req, 0);
        k_halt        = 1'b1;
        k_instr_ready = 1'b1;
        p0 = pop_cnt;
        repeat (6) step();
        check("t2_pops", pop_cnt - p0, 4);
        k_halt = 1'b0;

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset(3);
        step();
        step();
        k_redirect    = 1'b1;
        k_redirect_pc = 16'h0100;
        step();
        k_redirect = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            step();
            found = instr_valid;
        end
        check("t3_valid", instr_valid, 1);
        check("t3_first_pc", instr_pc, 16'h0100);

        // Redirect, response and pop all in one cycle.
        do_reset(1);
        repeat (4) step();
        k_redirect    = 1'b1;
        k_redirect_pc = 16'h0200;
        step();
        k_redirect = 1'b0;
        check("t4_pre_valid", instr_valid, 1);
        check("t4_pre_rsp", imem_rsp_valid, 1);
        step();
        check("t4_empty", instr_valid, 0);
        check("t4_err", err, 0);
        repeat (4) step();

        // Halt with two in flight: both delivered, no further issue.
        do_reset(3);
        step();
        step();
        k_halt = 1'b1;
        p0 = pop_cnt;
        i0 = issue_cnt;
        repeat (8) step();
        check("t5_pops", pop_cnt - p0, 2);
        check("t5_no_issue", issue_cnt - i0, 0);
        check("t5_req_off", imem_req, 0);
        k_halt = 1'b0;
        step();
        check("t5_req_on", imem_req, 1);

        // Misaligned redirect and address wrap.
        do_reset(1);
        repeat (3) step();
        k_redirect    = 1'b1;
        k_redirect_pc = 16'h0003;
        step();
        k_redirect = 1'b0;
        step();
        check("t6_err", err, 1);
        check("t6_addr", imem_addr, 16'h0002);
        repeat (3) step();
        check("t6_sticky", err, 1);
        k_redirect    = 1'b1;
        k_redirect_pc = 16'hFFFE;
        step();
        k_redirect = 1'b0;
        step();
        check("t6_addr_top", imem_addr, 16'hFFFE);
        step();
        check("t6_addr_wrap", imem_addr, 16'h0000);
        repeat (4) step();
        check("t6_err_kept", err, 1);

        // Randomised traffic with varying memory latency, then a bounded drain.
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(int'($urandom_range(1, 4)));
            repeat (600) begin
                k_instr_ready = ($urandom % 4) != 0;
                k_imem_ready  = ($urandom % 4) != 0;
                if (($urandom % 16) == 0) k_halt = !k_halt;
                k_redirect    = ($urandom % 32) == 0;
                k_redirect_pc = 16'($urandom) & 16'hFFFE;
                step();
            end
            k_redirect    = 1'b0;
            k_halt        = 1'b1;
            k_instr_ready = 1'b1;
            k_imem_ready  = 1'b1;
            for (int t = 0; t < 64 && (exp_q.size() != 0 || mem_q.size() != 0); t++) step();
            step();
            check("drain_empty", exp_q.size(), 0);
            check("drain_valid", instr_valid, 0);
            check("rand_err", err, 0);
            k_halt = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
